// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared LSU opcodes, FSM states, stage bundles and op helpers
package lsu_pkg;

    localparam int XLEN         = 32;
    localparam int LSU_OP_WIDTH = 4;

    typedef enum logic [LSU_OP_WIDTH-1:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LBU  = 4'd4,
        LSU_LHU  = 4'd5,
        LSU_SB   = 4'd6,
        LSU_SH   = 4'd7,
        LSU_SW   = 4'd8
    } lsu_op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0]         inst;
        logic [XLEN-1:0]         pc;
        logic [XLEN-1:0]         ex_result;
        logic [XLEN-1:0]         lsu_data;
        logic [LSU_OP_WIDTH-1:0] lsu_op;
        logic                    rw_en;
        logic [4:0]              rw_addr;
    } ex_info_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            rw_en;
        logic [4:0]      rw_addr;
        logic [XLEN-1:0] rw_data;
    } mem_info_t;

    function automatic logic op_is_load(input logic [LSU_OP_WIDTH-1:0] op);
        return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
               (op == LSU_LBU) || (op == LSU_LHU);
    endfunction

    function automatic logic op_is_store(input logic [LSU_OP_WIDTH-1:0] op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic logic op_misaligned(input logic [LSU_OP_WIDTH-1:0] op,
                                           input logic [1:0] a);
        logic half_op;
        logic word_op;
        half_op = (op == LSU_LH) || (op == LSU_LHU) || (op == LSU_SH);
        word_op = (op == LSU_LW) || (op == LSU_SW);
        return (half_op && a[0]) || (word_op && (a != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - store strobe/data replication and load lane shift/extend
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [LSU_OP_WIDTH-1:0] op,
    input  logic [1:0]              addr_lo,
    input  logic [XLEN-1:0]         store_data,
    input  logic [XLEN-1:0]         load_data,
    output logic [XLEN/8-1:0]       wstrb,
    output logic [XLEN-1:0]         wdata,
    output logic [XLEN-1:0]         load_result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Halfword lanes follow addr_lo[1] only; a set addr_lo[0] is ignored here.
    assign byte_lane = 8'(load_data >> {addr_lo, 3'b000});
    assign half_lane = 16'(load_data >> {addr_lo[1], 4'b0000});

    always_comb begin
        wstrb       = '0;
        wdata       = store_data;
        load_result = load_data;
        case (op)
            LSU_SB: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            LSU_SH: begin
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            LSU_SW:  wstrb = 4'b1111;
            LSU_LB:  load_result = {{24{byte_lane[7]}}, byte_lane};
            LSU_LBU: load_result = {24'd0, byte_lane};
            LSU_LH:  load_result = {{16{half_lane[15]}}, half_lane};
            LSU_LHU: load_result = {16'd0, half_lane};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage; MEM_ALIGN_CHECK_EN adds mem_ale
module mem_stage
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid,
    input  ex_info_t                ex_info,
    output logic                    mem_stall,
    output logic                    dmem_req_valid,
    input  logic                    dmem_req_ready,
    output logic                    dmem_req_we,
    output logic [DATA_WIDTH-1:0]   dmem_req_addr,
    output logic [DATA_WIDTH-1:0]   dmem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] dmem_req_wstrb,
    input  logic                    dmem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   dmem_resp_rdata,
    output logic                    mem_valid,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                    mem_ale,
`endif
    output mem_info_t               mem_info
);

    logic [1:0]            state_q;
    ex_info_t              hold_q;
    logic                  mem_valid_q;
    mem_info_t             mem_info_q;
    logic                  ex_mem_op;
    logic                  ex_mis;
    logic                  hold_store;
    logic [XLEN/8-1:0]     lane_wstrb;
    logic [XLEN-1:0]       lane_wdata;
    logic [XLEN-1:0]       lane_load;

    assign ex_mem_op  = op_is_load(ex_info.lsu_op) || op_is_store(ex_info.lsu_op);
    assign hold_store = op_is_store(hold_q.lsu_op);

`ifdef MEM_ALIGN_CHECK_EN
    logic mem_ale_q;

    assign ex_mis = op_misaligned(ex_info.lsu_op, ex_info.ex_result[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ale_q <= 1'b0;
        end else begin
            mem_ale_q <= (state_q == ST_IDLE) && ex_valid && ex_mis;
        end
    end

    assign mem_ale = mem_ale_q;
`else
    assign ex_mis = 1'b0;
`endif

    lsu_lane_align u_lane (
        .op          (hold_q.lsu_op),
        .addr_lo     (hold_q.ex_result[1:0]),
        .store_data  (hold_q.lsu_data),
        .load_data   (dmem_resp_rdata),
        .wstrb       (lane_wstrb),
        .wdata       (lane_wdata),
        .load_result (lane_load)
    );

    // Request payload is driven from holding regs only, so it stays stable until ready.
    assign mem_stall      = (state_q != ST_IDLE);
    assign dmem_req_valid = (state_q == ST_REQ);
    assign dmem_req_we    = dmem_req_valid && hold_store;
    assign dmem_req_addr  = dmem_req_valid ? {hold_q.ex_result[XLEN-1:2], 2'b00} : '0;
    assign dmem_req_wdata = dmem_req_we ? lane_wdata : '0;
    assign dmem_req_wstrb = dmem_req_we ? lane_wstrb : '0;
    assign mem_valid      = mem_valid_q;
    assign mem_info       = mem_info_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            mem_valid_q <= 1'b0;
            mem_info_q  <= '0;
        end else begin
            mem_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ex_valid) begin
                        if (ex_mem_op && !ex_mis) begin
                            hold_q  <= ex_info;
                            state_q <= ST_REQ;
                        end else begin
                            mem_valid_q        <= 1'b1;
                            mem_info_q.inst    <= ex_info.inst;
                            mem_info_q.pc      <= ex_info.pc;
                            mem_info_q.rw_en   <= ex_info.rw_en && !ex_mis;
                            mem_info_q.rw_addr <= ex_info.rw_addr;
                            mem_info_q.rw_data <= ex_info.ex_result;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_req_ready) begin
                        if (hold_store) begin
                            mem_valid_q        <= 1'b1;
                            mem_info_q.inst    <= hold_q.inst;
                            mem_info_q.pc      <= hold_q.pc;
                            mem_info_q.rw_en   <= hold_q.rw_en;
                            mem_info_q.rw_addr <= hold_q.rw_addr;
                            mem_info_q.rw_data <= hold_q.ex_result;
                            state_q            <= ST_IDLE;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem_resp_valid) begin
                        mem_valid_q        <= 1'b1;
                        mem_info_q.inst    <= hold_q.inst;
                        mem_info_q.pc      <= hold_q.pc;
                        mem_info_q.rw_en   <= hold_q.rw_en;
                        mem_info_q.rw_addr <= hold_q.rw_addr;
                        mem_info_q.rw_data <= lane_load;
                        state_q            <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed and randomized self-checking bench for mem_stage
module tb_mem_stage;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    ex_info_t    ex_info = '0;
    logic        mem_stall;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_resp_valid = 1'b0;
    logic [31:0] dmem_resp_rdata = '0;
    logic        mem_valid;
    mem_info_t   mem_info;
`ifdef MEM_ALIGN_CHECK_EN
    logic        mem_ale;
`endif

    int vectors = 0;
    int miscompares = 0;

    mem_stage #(.DATA_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid        (ex_valid),
        .ex_info         (ex_info),
        .mem_stall       (mem_stall),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_req_wstrb  (dmem_req_wstrb),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata),
        .mem_valid       (mem_valid),
`ifdef MEM_ALIGN_CHECK_EN
        .mem_ale         (mem_ale),
`endif
        .mem_info        (mem_info)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ex_info_t junk_info();
        ex_info_t j;
        j.inst = $urandom; j.pc = $urandom; j.ex_result = $urandom; j.lsu_data = $urandom;
        j.lsu_op = 4'($urandom_range(0, 15)); j.rw_en = 1'($urandom); j.rw_addr = 5'($urandom);
        return j;
    endfunction

    function automatic logic [3:0] ref_wstrb(input int op, input int a);
        if (op == 6) return 4'(1 << a);
        if (op == 7) return 4'(3 << (2 * (a / 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input int op, input logic [31:0] d);
        if (op == 6) return (d & 32'hFF) * 32'h0101_0101;
        if (op == 7) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input int op, input int a, input logic [31:0] r);
        longint v;
        if (op == 1 || op == 4) begin
            v = longint'((r >> (8 * a)) & 32'hFF);
            if (op == 1 && v > 127) v = v - 256;
        end else if (op == 2 || op == 5) begin
            v = longint'((r >> (16 * (a / 2))) & 32'hFFFF);
            if (op == 2 && v > 32767) v = v - 65536;
        end else begin
            v = longint'(r);
        end
        return v[31:0];
    endfunction

    task automatic chk_req(input int op, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic is_st);
        chk("req_valid", 32'(dmem_req_valid), 32'd1);
        chk("req_stall", 32'(mem_stall), 32'd1);
        chk("req_addr", dmem_req_addr, addr & 32'hFFFF_FFFC);
        chk("req_we", 32'(dmem_req_we), 32'(is_st));
        chk("req_no_valid", 32'(mem_valid), 32'd0);
        if (is_st) begin
            chk("req_wstrb", 32'(dmem_req_wstrb), 32'(ref_wstrb(op, int'(addr[1:0]))));
            chk("req_wdata", dmem_req_wdata, ref_wdata(op, sdata));
        end
    endtask

    task automatic chk_out(input string tag, input ex_info_t inf, input logic exp_en);
        chk({tag, "_valid"}, 32'(mem_valid), 32'd1);
        chk({tag, "_inst"}, mem_info.inst, inf.inst);
        chk({tag, "_pc"}, mem_info.pc, inf.pc);
        chk({tag, "_rw_en"}, 32'(mem_info.rw_en), 32'(exp_en));
        chk({tag, "_rw_addr"}, 32'(mem_info.rw_addr), 32'(inf.rw_addr));
    endtask

    // Entered at #1 after an edge with the stage idle; returns in the cycle mem_valid is seen.
    task automatic run_inst(input int op, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] rdata, input logic [4:0] rwa,
                            input int req_dly, input int resp_dly);
        ex_info_t inf;
        logic is_ld, is_st, mis;
        inf.inst = $urandom; inf.pc = $urandom; inf.ex_result = addr; inf.lsu_data = sdata;
        inf.lsu_op = 4'(op); inf.rw_en = 1'($urandom); inf.rw_addr = rwa;
        is_ld = (op >= 1 && op <= 5);
        is_st = (op >= 6 && op <= 8);
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = ((op == 2 || op == 5 || op == 7) && addr[0]) ||
              ((op == 3 || op == 8) && addr[1:0] != 2'b00);
`endif
        chk("accept_stall", 32'(mem_stall), 32'd0);
        ex_info = inf;
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        ex_info = junk_info();
        if (mis || !(is_ld || is_st)) begin
            chk_out("pass", inf, inf.rw_en && !mis);
            chk("pass_rw_data", mem_info.rw_data, addr);
            chk("pass_no_req", 32'(dmem_req_valid), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
            chk("pass_ale", 32'(mem_ale), 32'(mis));
`endif
            return;
        end
        for (int i = 0; i < req_dly; i++) begin
            chk_req(op, addr, sdata, is_st);
            dmem_resp_valid = 1'($urandom);
            step();
        end
        dmem_resp_valid = 1'b0;
        chk_req(op, addr, sdata, is_st);
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        if (is_st) begin
            chk_out("store", inf, inf.rw_en);
            chk("store_stall", 32'(mem_stall), 32'd0);
            return;
        end
        chk("wait_no_req", 32'(dmem_req_valid), 32'd0);
        chk("wait_stall", 32'(mem_stall), 32'd1);
        for (int i = 0; i < resp_dly; i++) begin
            step();
            chk("wait_no_valid", 32'(mem_valid), 32'd0);
            chk("wait_stall_hold", 32'(mem_stall), 32'd1);
        end
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = rdata;
        step();
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = $urandom;
        chk_out("load", inf, inf.rw_en);
        chk("load_rw_data", mem_info.rw_data, ref_load(op, int'(addr[1:0]), rdata));
`ifdef MEM_ALIGN_CHECK_EN
        chk("load_ale", 32'(mem_ale), 32'd0);
`endif
    endtask

    initial begin
        step();
        step();
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        chk("rst_req_addr", dmem_req_addr, 32'd0);
        chk("rst_req_wdata", dmem_req_wdata, 32'd0);
        chk("rst_req_wstrb", 32'(dmem_req_wstrb), 32'd0);
        chk("rst_rw_data", mem_info.rw_data, 32'd0);
        chk("rst_inst", mem_info.inst, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("rst_ale", 32'(mem_ale), 32'd0);
`endif
        rst = 1'b0;
        step();

        run_inst(0, 32'h1234, 32'h0, 32'h0, 5'd5, 0, 0);
        chk("add_rw_data_const", mem_info.rw_data, 32'h0000_1234);
        step();
        chk("pulse_low", 32'(mem_valid), 32'd0);

        run_inst(6, 32'h1003, 32'hAB, 32'h0, 5'd7, 0, 0);
        run_inst(1, 32'h2001, 32'h0, 32'h0000_8000, 5'd3, 0, 0);
        chk("lb_const", mem_info.rw_data, 32'hFFFF_FF80);
        run_inst(4, 32'h2001, 32'h0, 32'h0000_8000, 5'd3, 0, 0);
        chk("lbu_const", mem_info.rw_data, 32'h0000_0080);
        run_inst(3, 32'h4008, 32'h0, 32'hDEAD_BEEF, 5'd9, 3, 2);
        chk("lw_const", mem_info.rw_data, 32'hDEAD_BEEF);
`ifdef MEM_ALIGN_CHECK_EN
        run_inst(3, 32'h3002, 32'h0, 32'h0, 5'd4, 0, 0);
        chk("ale_const", 32'(mem_ale), 32'd1);
`endif

        for (int n = 0; n < 60; n++) begin
            run_inst($urandom_range(0, 10), $urandom, $urandom, $urandom,
                     5'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                step();
                chk("rand_pulse_low", 32'(mem_valid), 32'd0);
            end
        end

        ex_info = '0;
        ex_info.lsu_op = 4'd3;
        ex_info.ex_result = 32'h500;
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        chk("rstwait_in_wait", 32'(mem_stall), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstwait_stall", 32'(mem_stall), 32'd0);
        chk("rstwait_no_req", 32'(dmem_req_valid), 32'd0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h1111_2222;
        step();
        dmem_resp_valid = 1'b0;
        chk("rstwait_no_valid", 32'(mem_valid), 32'd0);
        step();
        chk("rstwait_no_valid2", 32'(mem_valid), 32'd0);
        chk("rstwait_idle", 32'(mem_stall), 32'd0);

        ex_info.lsu_op = 4'd8;
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        chk("rstreq_req", 32'(dmem_req_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstreq_withdrawn", 32'(dmem_req_valid), 32'd0);
        chk("rstreq_stall", 32'(mem_stall), 32'd0);
        step();
        chk("rstreq_no_valid", 32'(mem_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of writeback. It consumes the execute-stage bundle, performs byte/halfword/word loads and stores over a valid/ready data-memory port, sign/zero-extends load data, and presents a registered writeback bundle. It holds the execute stage via `mem_stall` while a memory transaction is outstanding.

## Interface
- `DATA_WIDTH`, 32: datapath and address width.
- `LSU_OP_WIDTH`, 4: width of `lsu_op`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ex_valid`  in  1  `ex_info` carries a valid instruction this cycle.
- `ex_info`  in  `ex_stage_if.i`  fields `inst` 32, `pc` 32, `ex_result` 32 (ALU result / effective address), `lsu_data` 32 (store data), `lsu_op` 4, `rw_en` 1, `rw_addr` 5.
- `mem_stall`  out  1  upstream must hold its current instruction.
- `dmem_req_valid`  out  1; `dmem_req_ready`  in  1.
- `dmem_req_we`  out  1; `dmem_req_addr`  out  32 (word-aligned); `dmem_req_wdata`  out  32; `dmem_req_wstrb`  out  4.
- `dmem_resp_valid`  in  1; `dmem_resp_rdata`  in  32.
- `mem_valid`  out  1  `mem_info` valid, one-cycle pulse per instruction.
- `mem_info`  out  `mem_stage_if.o`  fields `inst`, `pc`, `rw_en`, `rw_addr`, `rw_data` 32.
- `mem_ale`  out  1  misaligned-access flag (present only with `MEM_ALIGN_CHECK_EN`).

## Operation
- `lsu_op`: NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; other codes treated as NONE.
- FSM states IDLE, REQ, WAIT. `mem_stall` = (state != IDLE), derived from state only.
- IDLE, `ex_valid`, op NONE: next cycle `mem_valid`=1, `rw_data`=`ex_result`, other fields copied.
- IDLE, `ex_valid`, memory op: capture bundle into holding regs, go REQ.
- REQ: `dmem_req_valid`=1 from holding regs. On `dmem_req_ready`: store -> IDLE, `mem_valid`=1 next cycle; load -> WAIT.
- WAIT: on `dmem_resp_valid`: `rw_data` <= extended lane data, `mem_valid`=1 next cycle, -> IDLE. `dmem_resp_valid` ignored outside WAIT.
- Store lanes (a = `ex_result[1:0]`): SB wstrb=`0001<<a`, wdata=4x byte; SH wstrb=`0011<<{a[1],0}`, wdata=2x half; SW wstrb=1111.
- Load: `rdata >> 8*a` (halfword uses `a[1]`), LB/LH sign-extend, LBU/LHU zero-extend.
- `rw_en`, `rw_addr` passed unchanged; `mem_valid` low otherwise.

## Timing
- Reset: state IDLE; `mem_valid`, `mem_stall`, `dmem_req_valid`, `mem_ale`, all `mem_info` fields, all request outputs 0.
- Non-memory: accepted cycle N -> `mem_valid` N+1.
- Store, ready immediate: accepted N, request N+1 -> `mem_valid` N+2.
- Load, ready immediate, response next cycle: `mem_valid` N+3.
- `dmem_req_valid` held with stable payload until `ready`; never dropped except by reset.
- `rst` in REQ/WAIT: IDLE next edge, request withdrawn, later response ignored.
- Upstream presenting a new instruction in the same cycle FSM returns to IDLE is accepted that cycle.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: LH/LHU/SH with `a[0]`=1 or LW/SW with `a`!=0 take no memory request; next cycle `mem_valid`=1, `mem_ale`=1, `rw_en`=0. `mem_ale`=0 for all other outputs.
- Undefined: no `mem_ale` port; unused low address bits ignored (halfword uses `a[1]`, word uses lanes 0-3).

## Structure
- Shared package `lsu_pkg`: `lsu_op` encodings, `LSU_OP_WIDTH`, FSM state enum.
- Sub-module `lsu_lane_align`: combinational store strobe/data generation and load shift/extend.

## Test plan
- ADD result 0x1234, `rw_addr`=5 -> `mem_valid` next cycle, `rw_data`=0x1234, no request.
- SB addr 0x1003, data 0xAB -> wstrb 1000, wdata 0xABABABAB, addr 0x1000, `mem_valid` 2 cycles later.
- LB addr 0x2001, rdata 0x0000_8000 -> `rw_data` 0xFFFFFF80; LBU same -> 0x00000080.
- LW with `ready` low 3 cycles, response 2 cycles later -> payload stable, `mem_stall` high throughout, `rw_data`=rdata.
- `rst` asserted in WAIT, response then arrives -> IDLE, no `mem_valid`.
- With `MEM_ALIGN_CHECK_EN`: LW addr 0x3002 -> no request, `mem_ale`=1, `rw_en`=0.
